// File: rtl/collapse_key_pkg.sv
// Shared types, error codes and the CRC-8 step function for the collapse key reader.
package collapse_key_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_HOLD,
      ST_WIPE,
      ST_ERROR
   } state_t;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_NO_OE = 2'b01;
   localparam logic [1:0] ERR_CRC   = 2'b10;
   localparam logic [1:0] ERR_ABORT = 2'b11;

   localparam logic [7:0] CRC8_POLY = 8'h07;

   // One byte of CRC-8, MSB-first, no reflection.
   function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int b = 0; b < 8; b++)
         c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
      return c;
   endfunction

endpackage

// File: rtl/collapse_key_crc8.sv
// Byte-serial CRC-8 accumulator; clear has priority over enable.
module collapse_key_crc8
   import collapse_key_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       i_clear,
   input  logic       i_en,
   input  logic [7:0] i_data,
   output logic [7:0] o_crc
);

   logic [7:0] r_crc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)        r_crc <= 8'h00;
      else if (i_clear) r_crc <= 8'h00;
      else if (i_en)    r_crc <= crc8_byte(r_crc, i_data);
   end

   assign o_crc = r_crc;

endmodule

// File: rtl/collapse_key_reader.sv
// Sequential reader for a bank of read-once collapse registers; hands the key off over valid/ready.
// Build option: COLLAPSE_KEY_CRC_EN makes the last fragment a CRC-8 over the others.
module collapse_key_reader
   import collapse_key_pkg::*;
#(
   parameter int NUM_FRAG = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_start,
   input  logic                  i_abort,
   input  logic                  i_clear_err,
   output logic [NUM_FRAG-1:0]   o_read_strobe,
   input  logic [8*NUM_FRAG-1:0] i_frag_in,
   input  logic [NUM_FRAG-1:0]   i_frag_oe,
   output logic [8*NUM_FRAG-1:0] o_key,
   output logic                  o_key_valid,
   input  logic                  i_key_ready,
   output logic                  o_busy,
   output logic                  o_error,
   output logic [1:0]            o_err_code
);

   localparam int IW = $clog2(NUM_FRAG);
   localparam logic [IW-1:0] LAST = IW'(NUM_FRAG - 1);
   localparam logic [NUM_FRAG-1:0] ONE = NUM_FRAG'(1);

   state_t                r_state, w_state_nxt;
   logic [IW-1:0]         r_idx, w_idx_nxt;
   logic [8*NUM_FRAG-1:0] r_key, w_key_nxt;
   logic [1:0]            r_err, w_err_nxt;
   logic [7:0]            w_frag_byte;
   logic                  w_oe;
   logic                  w_crc_bad;
   logic [8*NUM_FRAG-1:0] w_key_mask;

   assign w_frag_byte = i_frag_in[{r_idx, 3'b000} +: 8];
   assign w_oe        = i_frag_oe[r_idx];

`ifdef COLLAPSE_KEY_CRC_EN
   logic       w_crc_clr, w_crc_en;
   logic [7:0] w_crc;

   assign w_crc_clr = ((r_state == ST_IDLE) && i_start) || (r_state == ST_WIPE);
   assign w_crc_en  = (r_state == ST_READ) && !i_abort && w_oe && (r_idx != LAST);

   collapse_key_crc8 u_crc (
      .clk     (clk),
      .reset   (reset),
      .i_clear (w_crc_clr),
      .i_en    (w_crc_en),
      .i_data  (w_frag_byte),
      .o_crc   (w_crc)
   );

   assign w_crc_bad  = (w_frag_byte != w_crc);
   // CRC byte is a check value, never key material.
   assign w_key_mask = {8'h00, {(8*NUM_FRAG-8){1'b1}}};
`else
   assign w_crc_bad  = 1'b0;
   assign w_key_mask = '1;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_key   <= '0;
         r_err   <= ERR_NONE;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_key   <= w_key_nxt;
         r_err   <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_key_nxt   = r_key;
      w_err_nxt   = r_err;
      case (r_state)
         ST_IDLE: if (i_start) begin
            w_state_nxt = ST_READ;
            w_idx_nxt   = '0;
            w_key_nxt   = '0;
         end
         ST_READ: begin
            if (i_abort) begin
               w_state_nxt = ST_WIPE;
               w_err_nxt   = ERR_ABORT;
            end else begin
               w_key_nxt[{r_idx, 3'b000} +: 8] = w_frag_byte;
               if (!w_oe) begin
                  w_state_nxt = ST_WIPE;
                  w_err_nxt   = ERR_NO_OE;
               end else if (r_idx != LAST) begin
                  w_idx_nxt = r_idx + IW'(1);
               end else if (w_crc_bad) begin
                  w_state_nxt = ST_WIPE;
                  w_err_nxt   = ERR_CRC;
               end else begin
                  w_state_nxt = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (i_abort) begin
               w_state_nxt = ST_WIPE;
               w_err_nxt   = ERR_ABORT;
            end else if (i_key_ready) begin
               w_state_nxt = ST_WIPE;
            end
         end
         ST_WIPE: begin
            w_key_nxt   = '0;
            w_idx_nxt   = '0;
            w_state_nxt = (r_err == ERR_NONE) ? ST_IDLE : ST_ERROR;
         end
         ST_ERROR: if (i_clear_err) begin
            w_state_nxt = ST_IDLE;
            w_err_nxt   = ERR_NONE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Strobe decoded only from registers so it cannot glitch.
   assign o_read_strobe = (r_state == ST_READ) ? (ONE << r_idx) : '0;
   assign o_key_valid   = (r_state == ST_HOLD);
   assign o_key         = o_key_valid ? (r_key & w_key_mask) : '0;
   assign o_busy        = (r_state != ST_IDLE) && (r_state != ST_ERROR);
   assign o_error       = (r_state == ST_ERROR);
   assign o_err_code    = r_err;

endmodule
